// File: rtl/serial_feeder_if.sv
// Handshake/stream bundle between a word source and serial_feeder.
// master = word source (drives data_in/load), slave = serial_feeder.
interface serial_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             ready;
  logic             busy;
  logic             x_out;
  logic             done;

  modport master (output data_in, load, input  ready, busy, x_out, done);
  modport slave  (input  data_in, load, output ready, busy, x_out, done);
endinterface

// File: rtl/serial_feeder.sv
// Parallel-to-serial stage: shifts a WIDTH-bit word out MSB-first, then pulses done.
// Define SER_PARITY_EN to append an even-parity bit after the data bits.
module serial_feeder #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic           clock,
  input  logic           reset,
  serial_feeder_if.slave sif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef SER_PARITY_EN
    ,PAR  = 2'd2
`endif
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             x_q;
  logic             done_q;
`ifdef SER_PARITY_EN
  logic             par;
`endif

  assign sif.ready = (state == IDLE);
  assign sif.busy  = (state != IDLE);
  assign sif.x_out = x_q;
  assign sif.done  = done_q;

  // x_q always mirrors the bit currently presented, so the MSB of sreg and
  // x_q agree during SHIFT; the last data bit hands off to PAR or IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
      x_q    <= IDLE_LEVEL;
      done_q <= 1'b0;
`ifdef SER_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          x_q <= IDLE_LEVEL;
          if (sif.load) begin
            state <= SHIFT;
            sreg  <= sif.data_in;
            x_q   <= sif.data_in[WIDTH-1];
            cnt   <= '0;
`ifdef SER_PARITY_EN
            par   <= ^sif.data_in;
`endif
          end
        end
        SHIFT: begin
          if (cnt == CW'(WIDTH - 1)) begin
`ifdef SER_PARITY_EN
            state  <= PAR;
            x_q    <= par;
`else
            state  <= IDLE;
            x_q    <= IDLE_LEVEL;
            done_q <= 1'b1;
`endif
          end else begin
            sreg <= sreg << 1;
            x_q  <= sreg[WIDTH-2];
            cnt  <= cnt + CW'(1);
          end
        end
`ifdef SER_PARITY_EN
        PAR: begin
          state  <= IDLE;
          x_q    <= IDLE_LEVEL;
          done_q <= 1'b1;
        end
`endif
        default: begin
          state <= IDLE;
          x_q   <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_feeder.sv
// Scoreboard bench for serial_feeder: a per-cycle expected stream is queued on
// accept and a negedge monitor pops and compares every cycle.
module tb_serial_feeder;
  localparam int   W    = 8;
  localparam logic IDLE = 1'b1;

  typedef struct packed {
    logic x;
    logic busy;
    logic ready;
    logic done;
  } exp_t;

  logic clock;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];

  serial_feeder_if #(.WIDTH(W)) sif ();

  serial_feeder #(.WIDTH(W), .IDLE_LEVEL(IDLE)) dut (
    .clock (clock),
    .reset (reset),
    .sif   (sif)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted word occupies W (+1 with parity) busy cycles, then one done/idle cycle.
  task automatic push_word(input logic [W-1:0] d);
    for (int k = 0; k < W; k++) begin
      logic b;
      b = ((d >> (W - 1 - k)) & 1) != 0;
      q.push_back('{x: b, busy: 1'b1, ready: 1'b0, done: 1'b0});
    end
`ifdef SER_PARITY_EN
    q.push_back('{x: ($countones(d) % 2) == 1, busy: 1'b1, ready: 1'b0, done: 1'b0});
`endif
    q.push_back('{x: IDLE, busy: 1'b0, ready: 1'b1, done: 1'b1});
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) e = q.pop_front();
    else              e = '{x: IDLE, busy: 1'b0, ready: 1'b1, done: 1'b0};
    chk("x_out", sif.x_out, e.x);
    chk("busy",  sif.busy,  e.busy);
    chk("ready", sif.ready, e.ready);
    chk("done",  sif.done,  e.done);
  end

  // One cycle of stimulus; an empty queue means the DUT is idle for the coming edge.
  task automatic drive_cycle(input logic ld, input logic [W-1:0] d, output logic acc);
    @(negedge clock);
    #1;
    sif.load    = ld;
    sif.data_in = d;
    acc = 1'b0;
    if (ld && reset && q.size() == 0) begin
      push_word(d);
      acc = 1'b1;
    end
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 40 && q.size() > 0; i++) drive_cycle(1'b0, '0, a);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end
    drive_cycle(1'b0, '0, a);
  endtask

  task automatic async_checks(input string tag);
    chk({tag, "_x_out"}, sif.x_out, IDLE);
    chk({tag, "_busy"},  sif.busy,  1'b0);
    chk({tag, "_ready"}, sif.ready, 1'b1);
    chk({tag, "_done"},  sif.done,  1'b0);
  endtask

  initial begin
    logic a;
    reset       = 1'b0;
    sif.load    = 1'b0;
    sif.data_in = '0;
    #41;
    async_checks("rst");
    reset = 1'b1;
    drive_cycle(1'b0, '0, a);
    drive_cycle(1'b0, '0, a);

    // single word
    drive_cycle(1'b1, 8'hA5, a);
    drain();

    // load while busy is ignored
    drive_cycle(1'b1, 8'hF0, a);
    drive_cycle(1'b0, 8'h00, a);
    drive_cycle(1'b1, 8'h0F, a);
    drive_cycle(1'b0, 8'h00, a);
    drain();

    // reset mid-word
    drive_cycle(1'b1, 8'h3C, a);
    drive_cycle(1'b0, 8'h00, a);
    drive_cycle(1'b0, 8'h00, a);
    @(negedge clock);
    #2;
    reset = 1'b0;
    q.delete();
    #1;
    async_checks("midrst");
    drive_cycle(1'b0, '0, a);
    drive_cycle(1'b0, '0, a);
    @(negedge clock);
    #2;
    reset = 1'b1;
    drive_cycle(1'b1, 8'h81, a);
    drain();

    // back-to-back with load held
    drive_cycle(1'b1, 8'h01, a);
    a = 1'b0;
    for (int i = 0; i < 20 && !a; i++) drive_cycle(1'b1, 8'h80, a);
    n_checks++;
    if (!a) begin
      n_fail++;
      $display("FAIL b2b_accept: got no accept expected accept within 20 cycles");
    end
    drive_cycle(1'b0, '0, a);
    drain();

    // parity words (plain stream when parity is compiled out)
    drive_cycle(1'b1, 8'h07, a);
    drain();
    drive_cycle(1'b1, 8'h03, a);
    drain();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] d;
      d = W'($urandom);
      drive_cycle($urandom_range(0, 2) == 0, d, a);
    end
    drive_cycle(1'b0, '0, a);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_feeder.md
# serial_feeder

Parallel-to-serial stimulus stage that sits directly upstream of the single-bit sequence-detector FSM and drives its `x_in` input. It accepts a `WIDTH`-bit word through a load/ready handshake and shifts the word out MSB-first, one bit per clock. It then returns `x_out` to a defined idle level and pulses `done`. This replaces hand-timed `x` toggling in benches, and it lets the detector be fed from a register or a ROM in the integrated design.

## Interface
Parameters:
- `WIDTH`, default 8: bits per word; legal range is 2 or greater.
- `IDLE_LEVEL`, default 1'b1: value driven on `x_out` whenever no word is being shifted.

Ports:
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: **asynchronous, active-low**. When low, the block is forced to IDLE immediately.
- `data_in`  in  WIDTH: word to serialize. It is sampled only on the accept edge.
- `load`  in  1: request to start a word.
- `ready`  out  1: high exactly when the state is IDLE.
- `busy`  out  1: high while a word (or its parity bit) is on `x_out`.
- `x_out`  out  1: serial stream. Connect it to the detector's `x_in`.
- `done`  out  1: one-cycle pulse after the last bit of a word.

## Operation
States and transitions:
- **IDLE**
  - `x_out` = `IDLE_LEVEL`, `ready` = 1, `busy` = 0.
  - `load` = 1 on a rising edge is an accept: go to SHIFT.
- **SHIFT**
  - The shift register holds the word; `x_out` is its MSB; the bit counter counts 0 .. WIDTH-1.
  - After the bit with count WIDTH-1, go to PAR if `SER_PARITY_EN` is defined, otherwise go to IDLE.
- **PAR** (only with `SER_PARITY_EN`)
  - `x_out` = stored parity bit for one cycle, then go to IDLE.

Rules:
- On the accept edge:
  - the shift register loads `data_in`;
  - `x_out` loads `data_in[WIDTH-1]`;
  - the counter is cleared;
  - the parity register loads `^data_in`.
- On each following SHIFT edge, shift left by one; `x_out` takes the next lower bit.
- The bit counter is `$clog2(WIDTH+1)` bits wide. It never wraps mid-word; it is cleared on accept.
- `load` is ignored while not in IDLE. `data_in` changes outside the accept edge have no effect.
- `done` is registered. It is asserted on the edge that returns the block to IDLE and is deasserted on the next edge.
- Asynchronous reset (`reset` = 0):
  - `state` = IDLE, `x_out` = `IDLE_LEVEL`, `ready` = 1, `busy` = 0, `done` = 0;
  - the counter, shift register and parity register are cleared.
- Reset mid-word aborts the word. No `done` pulse is produced, and the partial word is not resumed after reset is released.

## Timing
- All outputs change only on rising `clock` edges or on the asynchronous reset assertion. `ready` is decoded directly from the state register.
- Latency: bit k (MSB = bit 0) is on `x_out` during cycle k+1 after the accept edge, i.e. from edge k+1 to edge k+2. The edge at the end of the last bit/parity cycle returns the block to IDLE.
- Without parity:
  - `busy` is high for exactly WIDTH cycles;
  - `done` is high in cycle WIDTH+1, which coincides with the first IDLE cycle.
- With parity:
  - `busy` is high for WIDTH+1 cycles;
  - `done` is high in cycle WIDTH+2.
- Back-to-back operation: with `load` held high, consecutive words are separated by exactly one IDLE cycle at `IDLE_LEVEL`. The accept occurs on the edge that ends the IDLE/`done` cycle.
- The detector samples `x_out` on the same `clock`. Each bit is stable for one full period.

## Configuration
- `SER_PARITY_EN` defined:
  - a PAR state follows the data bits;
  - the parity bit = XOR of the word, giving even parity across WIDTH+1 bits;
  - `busy` and `done` timing extend by one cycle.
- `SER_PARITY_EN` undefined:
  - no PAR state and no parity register;
  - the stream is exactly WIDTH bits.

## Test plan
- Reset values:
  - Stimulus: hold `reset` = 0 for 40 time units with `load` = 0.
  - Required: `x_out` = 1, `ready` = 1, `busy` = 0, `done` = 0.
  - Release reset: outputs hold.
- Single word:
  - Stimulus: `data_in` = 8'hA5, `load` pulsed for 1 cycle.
  - Required: `x_out` = 1,0,1,0,0,1,0,1 in cycles 1–8; `done` = 1 in cycle 9; `x_out` = 1 from cycle 9.
- Load while busy:
  - Stimulus: accept 8'hF0, then pulse `load` with `data_in` = 8'h0F in cycle 3.
  - Required: the stream is 1,1,1,1,0,0,0,0 unchanged, and only one `done` pulse occurs.
- Reset mid-word:
  - Stimulus: accept 8'h3C; drop `reset` during cycle 3.
  - Required: `x_out` goes to 1 immediately, `busy` = 0 and `ready` = 1 without waiting for an edge, and no `done` pulse.
  - After release, a new 8'h81 word streams correctly.
- Back-to-back:
  - Stimulus: `load` held high with 8'h01 then 8'h80.
  - Required: 0,0,0,0,0,0,0,1, then one idle cycle at 1, then 1,0,0,0,0,0,0,0.
- Parity (`SER_PARITY_EN` defined):
  - Stimulus: 8'h07.
  - Required: 0,0,0,0,0,1,1,1 followed by parity bit 1; `done` in cycle 10.
  - Repeat with 8'h03: parity bit 0.
